// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_tx_pkg;

    // Frame shape: eight data bits, counted by a 3-bit index.
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W = 3;

    // Baud divisors for a 12 MHz system clock.
    localparam int unsigned B115200 = 104;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B38400  = 313;
    localparam int unsigned B19200  = 625;
    localparam int unsigned B9600   = 1250;

    // Transmitter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Rounded divisor for an arbitrary clock/baud pair.
    function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                  input int unsigned baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..BAUD_DIV-1 while enabled and flags the wrap cycle.
module uart_baud_tick #(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Count register; tick is registered so it marks the cycle holding the last count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == CNT_MAX);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a single-cycle start/ready accept handshake.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    tx_state_t             state;
    logic [7:0]            shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  accept;
    logic                  tick;
    logic                  baud_en;

    // ready is high exactly in IDLE, so this is the accept condition.
    assign accept  = start && ready;
    assign baud_en = (state != ST_IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rstn  (rstn),
        .clear (accept),
        .en    (baud_en),
        .tick  (tick)
    );

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            ready   <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_START;
                        shreg   <= data;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                            state   <= ST_STOP;
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            tx      <= shreg[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=4; samples on the falling edge.
module tb_uart_tx;

    localparam int unsigned B     = 4;
    localparam int          FRAME = 10 * B;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .BAUD_DIV (B)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check tx/ready at cycle j after an accept edge (j<0 means idle line).
    task automatic check_cycle(input string tag, input logic [7:0] b, input int j);
        logic [9:0] word;
        logic [9:0] sh;
        logic       etx;
        logic       erdy;
        int         slot;
        word = {1'b1, b, 1'b0};
        if (j >= 0 && j < FRAME) begin
            slot = j / B;
            sh   = word >> slot;
            etx  = sh[0];
            erdy = 1'b0;
        end else begin
            etx  = 1'b1;
            erdy = 1'b1;
        end
        check_eq($sformatf("%s tx j=%0d", tag, j), {31'd0, tx}, {31'd0, etx});
        check_eq($sformatf("%s ready j=%0d", tag, j), {31'd0, ready}, {31'd0, erdy});
    endtask

    initial begin
        int busy;
        rstn  = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset tx", {31'd0, tx}, 32'd1);
        check_eq("reset ready", {31'd0, ready}, 32'd1);
        rstn = 1'b1;

        // Idle line after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_cycle("idle", 8'h00, -1);
        end

        // 0x55: alternating line, ready low for exactly one frame.
        busy  = 0;
        start = 1'b1;
        data  = 8'h55;
        for (int j = 0; j <= FRAME; j++) begin
            @(negedge clk);
            check_cycle("f55", 8'h55, j);
            if (!ready) busy++;
            if (j == 0) start = 1'b0;
        end
        check_eq("f55 busy cycles", 32'(busy), 32'd40);

        // 0xA3 with data changed after accept and stray start pulses mid-frame.
        start = 1'b1;
        data  = 8'hA3;
        for (int j = 0; j <= FRAME + 4; j++) begin
            @(negedge clk);
            check_cycle("fa3", 8'hA3, j);
            if (j == 0) begin
                start = 1'b0;
                data  = 8'h00;
            end
            if (j == 7 || j == 22 || j == 39) start = 1'b1;
            if (j == 8 || j == 23 || j == 40) start = 1'b0;
        end

        // Back-to-back: start held high, 0x01 then 0xFF with one idle cycle between.
        start = 1'b1;
        data  = 8'h01;
        for (int j = 0; j <= 2 * FRAME + 2; j++) begin
            @(negedge clk);
            if (j <= FRAME) check_cycle("b2b01", 8'h01, j);
            else            check_cycle("b2bff", 8'hFF, j - FRAME - 1);
            if (j == 0) data = 8'hFF;
            if (j == FRAME + 1) start = 1'b0;
        end

        // Reset during data bit 3 of 0x0F, then a clean 0x81 frame.
        start = 1'b1;
        data  = 8'h0F;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            check_cycle("f0f", 8'h0F, j);
            if (j == 0) start = 1'b0;
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_eq("midrst tx", {31'd0, tx}, 32'd1);
        check_eq("midrst ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        check_cycle("midrst idle", 8'h00, -1);
        start = 1'b1;
        data  = 8'h81;
        for (int j = 0; j <= FRAME + 1; j++) begin
            @(negedge clk);
            check_cycle("f81", 8'h81, j);
            if (j == 0) start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
